// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: reads a 32-bit instruction one byte per cycle from a
// shared byte-wide RAM (1-cycle latency), assembles it little-endian and holds it for IF/ID.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy_i,
  input  logic              stall_hold_i,
  input  logic              redirect_i,
  input  logic [31:0]       redirect_pc_i,
  input  logic              mem_busy_i,
  output logic              ram_re_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  input  logic [7:0]        ram_rdata_i,
  output logic [31:0]       if_pc_o,
  output logic [31:0]       if_inst_o,
  output logic              if_valid_o,
  output logic              stall_req_o,
  output logic [0:0]        state_o
);

  localparam logic [0:0] ST_FETCH = 1'b0;
  localparam logic [0:0] ST_DONE  = 1'b1;

  // Handshake: if_valid_o=1 presents if_pc_o/if_inst_o; the word is consumed at a
  // rising edge where rdy_i=1, stall_hold_i=0 and redirect_i=0. A redirect drops it.
  logic [0:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [2:0]  issue_cnt_q, issue_cnt_d;
  logic [1:0]  recv_cnt_q, recv_cnt_d;
  logic        rd_pend_q, rd_pend_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic [31:0] fetch_addr;
  logic        issue;

  assign fetch_addr = pc_q + {29'b0, issue_cnt_q};
  assign issue      = rdy_i & ~rst & (state_q == ST_FETCH) & ~issue_cnt_q[2] & ~mem_busy_i;

  assign ram_re_o    = issue;
  assign ram_addr_o  = fetch_addr[ADDR_W-1:0];
  assign if_pc_o     = if_pc_q;
  assign if_inst_o   = if_inst_q;
  assign if_valid_o  = (state_q == ST_DONE);
  assign stall_req_o = ~if_valid_o;
  assign state_o     = state_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    issue_cnt_d = issue_cnt_q;
    recv_cnt_d  = recv_cnt_q;
    rd_pend_d   = issue;
    if_pc_d     = if_pc_q;
    if_inst_d   = if_inst_q;

    if (state_q == ST_FETCH) begin
      if (issue) issue_cnt_d = issue_cnt_q + 3'd1;
      // The returning byte is captured even while MEM holds the port this cycle.
      if (rd_pend_q) begin
        if_inst_d[{recv_cnt_q, 3'b000} +: 8] = ram_rdata_i;
        recv_cnt_d = recv_cnt_q + 2'd1;
        if (recv_cnt_q == 2'd3) begin
          if_pc_d = pc_q;
          state_d = ST_DONE;
        end
      end
    end else if (!stall_hold_i) begin
      pc_d        = pc_q + 32'd4;
      issue_cnt_d = 3'd0;
      recv_cnt_d  = 2'd0;
      state_d     = ST_FETCH;
    end

    // Redirect wins over capture and consume; the in-flight byte is discarded.
    if (redirect_i) begin
      pc_d        = redirect_pc_i;
      issue_cnt_d = 3'd0;
      recv_cnt_d  = 2'd0;
      rd_pend_d   = 1'b0;
      state_d     = ST_FETCH;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_FETCH;
      pc_q        <= RESET_PC;
      issue_cnt_q <= 3'd0;
      recv_cnt_q  <= 2'd0;
      rd_pend_q   <= 1'b0;
      if_pc_q     <= 32'd0;
      if_inst_q   <= 32'd0;
    end else if (rdy_i) begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
      rd_pend_q   <= rd_pend_d;
      if_pc_q     <= if_pc_d;
      if_inst_q   <= if_inst_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed timing scenarios followed by random traffic,
// with a scoreboard of expected {pc, instruction} words predicted from RAM contents.
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst, rdy, stall_hold, redirect, mem_busy;
  logic [31:0] redirect_pc;
  logic        ram_re;
  logic [31:0] ram_addr;
  logic [7:0]  ram_rdata = 8'h00;
  logic [31:0] if_pc, if_inst;
  logic        if_valid, stall_req;
  logic [0:0]  dbg_state;

  int n_checks = 0;
  int n_err    = 0;
  int n_pres   = 0;

  logic [7:0]  mem [256];
  logic [63:0] exp_q[$];
  logic [31:0] m_pc;

  logic        s_rst = 1'b0, s_rdy = 1'b0, s_redirect = 1'b0, s_valid = 1'b0, s_stall = 1'b0;
  logic [31:0] s_rpc = 32'h0;
  logic        p_valid = 1'b0, p_hold = 1'b0;
  logic [63:0] p_word = 64'h0;

  if_fetch_unit #(.RESET_PC(RESET_PC), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .rdy_i(rdy), .stall_hold_i(stall_hold),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc), .mem_busy_i(mem_busy),
    .ram_re_o(ram_re), .ram_addr_o(ram_addr), .ram_rdata_i(ram_rdata),
    .if_pc_o(if_pc), .if_inst_o(if_inst), .if_valid_o(if_valid),
    .stall_req_o(stall_req), .state_o(dbg_state)
  );

  always #5 clk = ~clk;

  // Shared RAM: 1-cycle read latency; MEM-stage accesses scramble the data bus.
  always @(posedge clk) begin
    if (rdy) begin
      if (ram_re) ram_rdata <= mem[ram_addr[7:0]];
      else if (mem_busy) ram_rdata <= 8'($urandom);
    end
  end

  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [31:0] w;
    logic [31:0] b;
    w = 32'h0;
    for (int i = 0; i < 4; i++) begin
      b = a + i;
      w[8*i +: 8] = mem[b[7:0]];
    end
    return w;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: which word the fetch unit must present next.
  always @(posedge clk) begin
    if (s_rst) begin
      exp_q.delete();
      m_pc = RESET_PC;
      exp_q.push_back({m_pc, word_at(m_pc)});
    end else if (s_rdy) begin
      if (s_redirect) begin
        exp_q.delete();
        m_pc = s_rpc;
        exp_q.push_back({m_pc, word_at(m_pc)});
      end else if (s_valid && !s_stall) begin
        m_pc = m_pc + 32'd4;
        exp_q.push_back({m_pc, word_at(m_pc)});
      end
    end
  end

  // Monitor: per-cycle protocol rules plus scoreboard pop on each new presentation.
  always @(negedge clk) begin
    logic [63:0] e;
    if (!rst) begin
      chk("stall_req", stall_req, !if_valid);
      chk("state_dbg", dbg_state, if_valid);
      if (mem_busy) chk("re_with_busy", ram_re, 1'b0);
      if (!rdy) chk("re_frozen", ram_re, 1'b0);
      if (if_valid) chk("re_in_done", ram_re, 1'b0);
      if (ram_re && exp_q.size() > 0) chk("addr_window", (ram_addr - exp_q[0][63:32]) < 32'd4, 1'b1);
      if (p_hold) begin
        chk("hold_valid", if_valid, 1'b1);
        chk("hold_word", {if_pc, if_inst}, p_word);
      end
      if (if_valid && !p_valid) begin
        n_pres++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL word_unexpected: got %h expected none", {if_pc, if_inst});
        end else begin
          e = exp_q.pop_front();
          chk("word", {if_pc, if_inst}, e);
        end
      end
    end
    p_valid    = rst ? 1'b0 : if_valid;
    p_hold     = !rst && rdy && if_valid && stall_hold && !redirect;
    p_word     = {if_pc, if_inst};
    s_rst      = rst;
    s_rdy      = rdy;
    s_redirect = redirect;
    s_rpc      = redirect_pc;
    s_valid    = if_valid;
    s_stall    = stall_hold;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'h10; mem[3] = 8'h00;
    rst = 1'b1; rdy = 1'b1; stall_hold = 1'b0; redirect = 1'b0; mem_busy = 1'b0;
    redirect_pc = 32'h0;

    repeat (2) @(posedge clk);
    smp();
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_inst", if_inst, 32'h0);
    chk("rst_valid", if_valid, 1'b0);
    chk("rst_stall_req", stall_req, 1'b1);
    chk("rst_re", ram_re, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Uncontended fetch from address 0.
    for (int c = 0; c < 7; c++) begin
      smp();
      if (c < 4) begin
        chk("t1_re", ram_re, 1'b1);
        chk("t1_addr", ram_addr, 32'(c));
      end
      if (c == 4) begin
        chk("t1_re_idle", ram_re, 1'b0);
        chk("t1_valid_early", if_valid, 1'b0);
      end
      if (c == 5) begin
        chk("t1_valid", if_valid, 1'b1);
        chk("t1_inst", if_inst, 32'h00100513);
        chk("t1_pc", if_pc, 32'h0);
      end
      if (c == 6) begin
        chk("t1_next_re", ram_re, 1'b1);
        chk("t1_next_addr", ram_addr, 32'h4);
      end
      cyc();
    end

    // MEM owns the port in cycles 1-2 of the fetch at 4.
    for (int c = 1; c < 8; c++) begin
      if (c == 1) mem_busy = 1'b1;
      if (c == 3) mem_busy = 1'b0;
      smp();
      if (c < 3) chk("t2_busy_re", ram_re, 1'b0);
      if (c >= 3 && c <= 5) begin
        chk("t2_re", ram_re, 1'b1);
        chk("t2_addr", ram_addr, 32'(4 + c - 2));
      end
      if (c == 6) chk("t2_valid_early", if_valid, 1'b0);
      if (c == 7) begin
        chk("t2_valid", if_valid, 1'b1);
        chk("t2_pc", if_pc, 32'h4);
        chk("t2_inst", if_inst, word_at(32'h4));
      end
      cyc();
    end

    // IF/ID holds for three cycles while the word at 8 is presented.
    for (int c = 0; c < 10; c++) begin
      if (c == 0) stall_hold = 1'b1;
      if (c == 8) stall_hold = 1'b0;
      smp();
      if (c == 0) chk("t3_addr", ram_addr, 32'h8);
      if (c >= 5 && c <= 7) begin
        chk("t3_hold_valid", if_valid, 1'b1);
        chk("t3_hold_pc", if_pc, 32'h8);
        chk("t3_hold_inst", if_inst, word_at(32'h8));
        chk("t3_hold_re", ram_re, 1'b0);
      end
      if (c == 9) begin
        chk("t3_next_re", ram_re, 1'b1);
        chk("t3_next_addr", ram_addr, 32'hC);
      end
      cyc();
    end

    // Redirect to 0x100 in cycle 2 of the fetch at 12.
    for (int c = 1; c < 9; c++) begin
      if (c == 2) begin redirect = 1'b1; redirect_pc = 32'h100; end
      if (c == 3) redirect = 1'b0;
      smp();
      if (c == 2) chk("t4_addr_old", ram_addr, 32'hE);
      if (c == 3) begin
        chk("t4_re", ram_re, 1'b1);
        chk("t4_addr", ram_addr, 32'h100);
      end
      if (c == 7) chk("t4_valid_early", if_valid, 1'b0);
      if (c == 8) begin
        chk("t4_valid", if_valid, 1'b1);
        chk("t4_pc", if_pc, 32'h100);
        chk("t4_inst", if_inst, word_at(32'h100));
      end
      cyc();
    end

    // Redirect to 0x40 while the word at 0x104 is presented and not stalled.
    for (int c = 0; c < 7; c++) begin
      if (c == 5) begin redirect = 1'b1; redirect_pc = 32'h40; end
      if (c == 6) redirect = 1'b0;
      smp();
      if (c == 0) chk("t5_addr", ram_addr, 32'h104);
      if (c == 5) chk("t5_valid", if_valid, 1'b1);
      if (c == 6) begin
        chk("t5_re", ram_re, 1'b1);
        chk("t5_addr_redir", ram_addr, 32'h40);
        chk("t5_valid_drop", if_valid, 1'b0);
      end
      cyc();
    end

    // Wrap past 0xFFFFFFFF with rdy low for four cycles.
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    cyc();
    redirect = 1'b0;
    for (int w = 0; w < 10; w++) begin
      if (w == 2) rdy = 1'b0;
      if (w == 6) rdy = 1'b1;
      smp();
      if (w == 0) chk("t6_addr_fe", ram_addr, 32'hFFFF_FFFE);
      if (w == 1) chk("t6_addr_ff", ram_addr, 32'hFFFF_FFFF);
      if (w >= 2 && w <= 5) chk("t6_paused_re", ram_re, 1'b0);
      if (w == 6) begin
        chk("t6_re_00", ram_re, 1'b1);
        chk("t6_addr_00", ram_addr, 32'h0);
      end
      if (w == 7) chk("t6_addr_01", ram_addr, 32'h1);
      if (w == 8) chk("t6_valid_early", if_valid, 1'b0);
      if (w == 9) begin
        chk("t6_valid", if_valid, 1'b1);
        chk("t6_pc", if_pc, 32'hFFFF_FFFE);
        chk("t6_inst", if_inst, word_at(32'hFFFF_FFFE));
      end
      cyc();
    end

    // Random traffic, checked by the scoreboard and monitor rules.
    for (int i = 0; i < 1500; i++) begin
      rdy         = ($urandom_range(0, 9) != 0);
      mem_busy    = ($urandom_range(0, 2) == 0);
      stall_hold  = ($urandom_range(0, 2) == 0);
      redirect    = ($urandom_range(0, 29) == 0);
      redirect_pc = $urandom;
      cyc();
    end
    rdy = 1'b1; mem_busy = 1'b0; stall_hold = 1'b0; redirect = 1'b0;
    repeat (20) cyc();
    chk("liveness", n_pres >= 50, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
